// File: rtl/adder47_accum_sequencer_if.sv
// Handshake bundle for the accumulation sequencer: command, addend and result channels.
interface adder47_accum_sequencer_if #(
  parameter int ACC_W = 47,
  parameter int ADD_W = 21,
  parameter int CNT_W = 6
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [ACC_W-1:0] cmd_base;
  logic [CNT_W-1:0] cmd_count;
  logic             add_valid;
  logic             add_ready;
  logic [ADD_W-1:0] add_data;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_sum;
  logic             res_ovf;
  logic             busy;

  // Producer/consumer side that talks to the sequencer.
  modport master (
    output cmd_valid, cmd_base, cmd_count, add_valid, add_data, res_ready,
    input  cmd_ready, add_ready, res_valid, res_sum, res_ovf, busy
  );

  // The sequencer itself.
  modport slave (
    input  cmd_valid, cmd_base, cmd_count, add_valid, add_data, res_ready,
    output cmd_ready, add_ready, res_valid, res_sum, res_ovf, busy
  );
endinterface

// File: rtl/adder47_accum_sequencer.sv
// Multi-cycle accumulation controller: one 47+21 bit adder reused for up to 63 addends
// per command, returning the wrapped sum and a sticky carry-out flag.
module adder47_accum_sequencer #(
  parameter int ACC_W = 47,
  parameter int ADD_W = 21,
  parameter int CNT_W = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       abort,
  adder47_accum_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Zero-extends the addend and returns {carry, sum} of the single shared adder.
  function automatic logic [ACC_W:0] add_zext(input logic [ACC_W-1:0] a,
                                               input logic [ADD_W-1:0] b);
    add_zext = {1'b0, a} + {{(ACC_W+1-ADD_W){1'b0}}, b};
  endfunction

  state_t           state_r;
  logic [ACC_W-1:0] acc_r;
  logic             ovf_r;
  logic [CNT_W-1:0] remaining_r;
  logic             cmd_ready_r;
  logic             add_ready_r;
  logic             res_valid_r;
  logic [ACC_W-1:0] res_sum_r;
  logic             res_ovf_r;
  logic             busy_r;

  logic [ACC_W:0]   add_out_s;
  logic             ovf_next_s;

  assign add_out_s  = add_zext(acc_r, bus.add_data);
  assign ovf_next_s = ovf_r | add_out_s[ACC_W];

  // Sequencer FSM; every output flop is written together with the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state_r     <= ST_IDLE;
      acc_r       <= ACC_ZERO;
      ovf_r       <= 1'b0;
      remaining_r <= CNT_ZERO;
      cmd_ready_r <= 1'b1;
      add_ready_r <= 1'b0;
      res_valid_r <= 1'b0;
      res_sum_r   <= ACC_ZERO;
      res_ovf_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            acc_r       <= bus.cmd_base;
            ovf_r       <= 1'b0;
            remaining_r <= bus.cmd_count;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            if (bus.cmd_count == CNT_ZERO) begin
              // Empty command: the base is the result, straight to DONE.
              state_r     <= ST_DONE;
              res_valid_r <= 1'b1;
              res_sum_r   <= bus.cmd_base;
              res_ovf_r   <= 1'b0;
            end else begin
              state_r     <= ST_ACCUM;
              add_ready_r <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCUM: begin
          if (bus.add_valid) begin
            acc_r       <= add_out_s[ACC_W-1:0];
            ovf_r       <= ovf_next_s;
            remaining_r <= remaining_r - CNT_ONE;
            if (remaining_r == CNT_ONE) begin
              // Last addend: publish the fresh sum in the same edge.
              state_r     <= ST_DONE;
              add_ready_r <= 1'b0;
              res_valid_r <= 1'b1;
              res_sum_r   <= add_out_s[ACC_W-1:0];
              res_ovf_r   <= ovf_next_s;
            end else begin
              state_r <= ST_ACCUM;
            end
          end else begin
            state_r <= ST_ACCUM;
          end
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            state_r     <= ST_IDLE;
            res_valid_r <= 1'b0;
            res_sum_r   <= ACC_ZERO;
            res_ovf_r   <= 1'b0;
            busy_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean IDLE.
          state_r     <= ST_IDLE;
          acc_r       <= ACC_ZERO;
          ovf_r       <= 1'b0;
          remaining_r <= CNT_ZERO;
          cmd_ready_r <= 1'b1;
          add_ready_r <= 1'b0;
          res_valid_r <= 1'b0;
          res_sum_r   <= ACC_ZERO;
          res_ovf_r   <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.add_ready = add_ready_r;
  assign bus.res_valid = res_valid_r;
  assign bus.res_sum   = res_sum_r;
  assign bus.res_ovf   = res_ovf_r;
  assign bus.busy      = busy_r;

endmodule
